// File: rtl/ram2m_dma_pkg.sv
// ram2m_dma_pkg: shared widths, command modes and state encoding for the RAM block-transfer engine
package ram2m_dma_pkg;
    localparam int AW = 21;
    localparam int DW = 16;
    localparam int LW = 22;
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/ram2m_dma_addr_gen.sv
// ram2m_dma_addr_gen: loadable address pointer stepping by +/-1, wrapping modulo 2^AW
module ram2m_dma_addr_gen
    import ram2m_dma_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          step,
    input  logic          dec,
    output logic [AW-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (load)
            ptr <= load_val;
        else if (step)
            ptr <= dec ? ptr - AW'(1) : ptr + AW'(1);
    end
endmodule

// File: rtl/ram2m_dma.sv
// ram2m_dma: one-word-per-clock copy/fill engine owning the RAM write port and read port A
module ram2m_dma
    import ram2m_dma_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_mode,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_fill,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] remaining,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0] cpu_d_in,
    output logic          cpu_wr_ready,
    input  logic [AW-1:0] cpu_rd_addr,
    output logic          mem_wr,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_d_in,
    output logic [AW-1:0] mem_rd_addr_a,
    output logic [AW-1:0] mem_rd_addr_b,
    input  logic [DW-1:0] mem_d_out_a
);
    logic [0:0]    state;
    logic          mode;
    logic          dec;
    logic [DW-1:0] fill;
    logic [AW-1:0] src_ptr, dst_ptr, src_load, dst_load, len_m1;
    logic          run, accept, cmd_dec;

    assign run      = state == ST_RUN;
    assign accept   = cmd_valid && cmd_ready;
    // copying upward into an overlapping range must walk from the top end down
    assign cmd_dec  = cmd_mode == MODE_COPY && cmd_dst > cmd_src;
    assign len_m1   = cmd_len[AW-1:0] - AW'(1);
    assign src_load = cmd_dec ? cmd_src + len_m1 : cmd_src;
    assign dst_load = cmd_dec ? cmd_dst + len_m1 : cmd_dst;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode      <= MODE_COPY;
            dec       <= 1'b0;
            fill      <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mode      <= cmd_mode;
                dec       <= cmd_dec;
                fill      <= cmd_fill;
                remaining <= cmd_len;
                state     <= cmd_len != '0 ? ST_RUN : ST_IDLE;
                done      <= cmd_len == '0;
            end else if (run) begin
                remaining <= remaining - LW'(1);
                if (remaining == LW'(1)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    ram2m_dma_addr_gen u_src (
        .clk(clk), .reset(reset), .load(accept), .load_val(src_load),
        .step(run), .dec(dec), .ptr(src_ptr)
    );

    ram2m_dma_addr_gen u_dst (
        .clk(clk), .reset(reset), .load(accept), .load_val(dst_load),
        .step(run), .dec(dec), .ptr(dst_ptr)
    );

    assign busy          = run;
    assign cmd_ready     = !run;
    assign cpu_wr_ready  = !run;
    assign mem_wr        = !reset && (run || cpu_wr);
    assign mem_wr_addr   = run ? dst_ptr : cpu_wr_addr;
    assign mem_d_in      = run ? (mode == MODE_FILL ? fill : mem_d_out_a) : cpu_d_in;
    assign mem_rd_addr_a = run ? src_ptr : '0;
    assign mem_rd_addr_b = cpu_rd_addr;
endmodule

// File: tb/tb_ram2m_dma.sv
// tb_ram2m_dma: scoreboard bench for ram2m_dma driving a behavioural 2M x 16 RAM
module tb_ram2m_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_mode;
    logic [20:0] cmd_src, cmd_dst;
    logic [21:0] cmd_len;
    logic [15:0] cmd_fill;
    logic        busy, done;
    logic [21:0] remaining;
    logic        cpu_wr, cpu_wr_ready;
    logic [20:0] cpu_wr_addr, cpu_rd_addr;
    logic [15:0] cpu_d_in;
    logic        mem_wr;
    logic [20:0] mem_wr_addr, mem_rd_addr_a, mem_rd_addr_b;
    logic [15:0] mem_d_in, mem_d_out_a;

    typedef struct {
        logic [20:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] model[int];
    logic [15:0] ram[0:(1<<21)-1];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wr) ram[mem_wr_addr] <= mem_d_in;
    assign mem_d_out_a = ram[mem_rd_addr_a];

    ram2m_dma dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .busy(busy), .done(done), .remaining(remaining),
        .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_d_in(cpu_d_in),
        .cpu_wr_ready(cpu_wr_ready), .cpu_rd_addr(cpu_rd_addr),
        .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_d_in(mem_d_in),
        .mem_rd_addr_a(mem_rd_addr_a), .mem_rd_addr_b(mem_rd_addr_b),
        .mem_d_out_a(mem_d_out_a)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // every RAM write must match the next expected write in order
    always @(negedge clk) begin
        if (mem_wr) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(mem_wr_addr), 32'(e.a));
                check("wr_data", 32'(mem_d_in), 32'(e.d));
            end
        end
    end

    task automatic expect_wr(input logic [20:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
        model[int'(a)] = d;
    endtask

    task automatic cpu_write(input logic [20:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        cpu_wr = 1'b1; cpu_wr_addr = a; cpu_d_in = d;
        expect_wr(a, d);
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic check_ram(input string tag, input logic [20:0] a, input logic [15:0] exp);
        check(tag, 32'(ram[a]), 32'(exp));
    endtask

    task automatic run_cmd(input logic mode, input logic [20:0] src, input logic [20:0] dst,
                           input logic [21:0] len, input logic [15:0] fill,
                           input logic host_acc, input logic host_run);
        logic        dn;
        logic [21:0] idx;
        logic [20:0] s, d;
        logic [15:0] v;
        int          cnt;
        logic        got;
        @(posedge clk); #1;
        cmd_mode = mode; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill;
        cmd_valid = 1'b1;
        cpu_wr_addr = 21'h50; cpu_d_in = 16'h7;
        cpu_wr = host_acc;
        if (host_acc) expect_wr(21'h50, 16'h7);
        dn = !mode && dst > src;
        for (int i = 0; i < int'(len); i++) begin
            idx = dn ? len - 22'(i) - 22'd1 : 22'(i);
            s = src + idx[20:0];
            d = dst + idx[20:0];
            v = mode ? fill : (model.exists(int'(s)) ? model[int'(s)] : 16'h0);
            expect_wr(d, v);
        end
        @(negedge clk);
        check("cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cpu_wr = host_run && len != 0;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt <= int'(len) + 4) begin
            cpu_rd_addr = 21'($urandom);
            @(negedge clk);
            check("rd_addr_b", 32'(mem_rd_addr_b), 32'(cpu_rd_addr));
            if (done) got = 1'b1;
            else begin
                check("busy", 32'(busy), 32'(len != 0));
                check("remaining", 32'(remaining), 32'(len - 22'(cnt)));
                if (len != 0) check("cpu_wr_ready", 32'(cpu_wr_ready), 0);
                @(posedge clk); #1;
                cnt++;
                cpu_wr = host_run && cnt < int'(len);
            end
        end
        cpu_wr = 1'b0;
        check("done_seen", 32'(got), 1);
        check("done_lat", 32'(cnt), 32'(len));
        check("busy_at_done", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("sb_drain", 32'(sb.size()), 0);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_fill = '0;
        cpu_wr = 1'b1; cpu_wr_addr = 21'h3; cpu_d_in = 16'h9; cpu_rd_addr = 21'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_rd_b", 32'(mem_rd_addr_b), 32'h1234);
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_remaining", 32'(remaining), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_cpu_ready", 32'(cpu_wr_ready), 1);
        check("rst_rd_a", 32'(mem_rd_addr_a), 0);

        cpu_write(21'h14, 16'hDEAD);
        cpu_write(21'h50, 16'h3);
        cpu_write(21'h202, 16'hCAFE);
        cpu_write(21'h2, 16'hBEEF);

        run_cmd(1'b1, 21'h0, 21'h10, 22'd4, 16'hA5A5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_ram("fill_word", 21'h10 + 21'(i), 16'hA5A5);
        check_ram("fill_after", 21'h14, 16'hDEAD);

        for (int i = 0; i < 5; i++) cpu_write(21'h100 + 21'(i), 16'(i + 1));
        run_cmd(1'b0, 21'h101, 21'h100, 22'd4, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_ram("asc_copy", 21'h100 + 21'(i), 16'(i + 2));

        for (int i = 0; i < 5; i++) cpu_write(21'h100 + 21'(i), 16'(i + 1));
        run_cmd(1'b0, 21'h100, 21'h101, 22'd4, 16'h0, 1'b0, 1'b0);
        check_ram("desc_base", 21'h100, 16'h1);
        for (int i = 0; i < 4; i++) check_ram("desc_copy", 21'h101 + 21'(i), 16'(i + 1));

        run_cmd(1'b1, 21'h0, 21'h1FFFFE, 22'd4, 16'h1234, 1'b0, 1'b0);
        check_ram("wrap_fffe", 21'h1FFFFE, 16'h1234);
        check_ram("wrap_ffff", 21'h1FFFFF, 16'h1234);
        check_ram("wrap_0", 21'h0, 16'h1234);
        check_ram("wrap_1", 21'h1, 16'h1234);
        check_ram("wrap_after", 21'h2, 16'hBEEF);

        run_cmd(1'b1, 21'h0, 21'h300, 22'd5, 16'h5555, 1'b0, 1'b1);
        check_ram("host_run_ignored", 21'h50, 16'h3);
        run_cmd(1'b1, 21'h0, 21'h340, 22'd3, 16'h6666, 1'b1, 1'b0);
        check_ram("host_at_accept", 21'h50, 16'h7);

        run_cmd(1'b1, 21'h0, 21'h400, 22'd0, 16'h7777, 1'b0, 1'b0);

        // reset lands on the third RUN cycle of a 10-word fill
        @(posedge clk); #1;
        cmd_mode = 1'b1; cmd_dst = 21'h200; cmd_len = 22'd10; cmd_fill = 16'h4242; cmd_valid = 1'b1;
        expect_wr(21'h200, 16'h4242);
        expect_wr(21'h201, 16'h4242);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_run_mem_wr", 32'(mem_wr), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_busy", 32'(busy), 0);
        for (int i = 0; i < 12; i++) begin
            check("post_rst_nodone", 32'(done), 0);
            @(negedge clk);
        end
        check_ram("rst_w0", 21'h200, 16'h4242);
        check_ram("rst_w1", 21'h201, 16'h4242);
        check_ram("rst_untouched", 21'h202, 16'hCAFE);
        check("rst_sb_drain", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram2m_dma.md
Name: ram2m_dma

Overview:
Block-transfer engine sitting directly upstream of the 2M x 16 RAM (ram2m). It owns the RAM write port (wr/wr_addr/d_in) and read port A. It executes copy and fill commands at one word per clock. It also forwards host (CPU) writes to the RAM when idle, and always forwards host reads to port B.

Parameters:
AW, 21, word address width (2M words)
DW, 16, data width
LW, 22, length field width (allows a full 2^21-word transfer)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept (high only in IDLE)
cmd_mode  in  1  0 = copy, 1 = fill
cmd_src  in  AW  copy source start address
cmd_dst  in  AW  destination start address
cmd_len  in  LW  word count
cmd_fill  in  DW  fill value
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
remaining  out  LW  words left in current transfer
cpu_wr  in  1  host write request
cpu_wr_addr  in  AW  host write address
cpu_d_in  in  DW  host write data
cpu_wr_ready  out  1  host write accepted this cycle (= !busy)
cpu_rd_addr  in  AW  host read address
mem_wr  out  1  to RAM wr
mem_wr_addr  out  AW  to RAM wr_addr
mem_d_in  out  DW  to RAM d_in
mem_rd_addr_a  out  AW  to RAM rd_addr_a
mem_rd_addr_b  out  AW  to RAM rd_addr_b
mem_d_out_a  in  DW  from RAM d_out_a

Behaviour:
- RAM contract: the write commits on the rising clk edge while mem_wr=1. Reads are combinational from address. A read and a write in the same cycle return the old data.
- States: IDLE, RUN.
- Reset values: state=IDLE, busy=0, done=0, remaining=0, pointers=0, mem_wr=0. mem_wr is forced to 0 in any cycle where reset=1.
- IDLE:
  - cmd_ready=1.
  - mem_wr=cpu_wr, mem_wr_addr=cpu_wr_addr, mem_d_in=cpu_d_in (combinational passthrough).
  - mem_rd_addr_a=0.
- Accept:
  - A command is taken when cmd_valid && cmd_ready at the edge. It latches mode, len, fill value and pointers.
  - A host write in the same cycle still commits, because it is still IDLE.
  - cmd_len=0: no transition to RUN; done pulses the next cycle; busy stays 0; no RAM writes.
- Direction (copy only):
  - Descending iff cmd_dst > cmd_src (unsigned). Pointers then start at src+len-1 and dst+len-1, mod 2^21.
  - Otherwise ascending from src and dst.
  - Fill is always ascending.
- RUN, each cycle:
  - busy=1, cmd_ready=0, cpu_wr_ready=0. Host writes are ignored, not queued.
  - mem_rd_addr_a=src_ptr.
  - mem_wr=1, mem_wr_addr=dst_ptr.
  - mem_d_in = mem_d_out_a (copy) or fill value (fill).
  - Pointers step by ±1, wrapping modulo 2^21; remaining decrements.
- Termination: on the edge where remaining goes 1 -> 0, state returns to IDLE. done=1 for exactly one cycle after that edge, and busy=0 in that cycle.
- Latency: N words take exactly N RUN cycles; done is asserted N cycles after acceptance.
- mem_rd_addr_b = cpu_rd_addr at all times, in every state.
- Overlapping copy whose ranges wrap across address 0: result is unspecified. Non-wrapping overlap in either direction copies correctly.
- Reset mid-RUN: at the reset edge the engine goes to IDLE, no done pulse is issued, and memory already written stays written.

Decomposition:
- Shared package: AW/DW/LW constants, mode encodings (MODE_COPY=0, MODE_FILL=1), state encoding.
- One natural sub-module, ram2m_dma_addr_gen: a pointer register with load value, ±1 step and modulo-2^21 wrap. Instantiate it twice (src, dst).
- Test bench instantiates ram2m_dma driving a real ram2m.

Test Plan:
- Fill: dst=0x00010, len=4, fill=0xA5A5 -> words 0x10..0x13 = 0xA5A5; 0x14 unchanged; done pulses 4 cycles after acceptance.
- Ascending overlapped copy: preload 0x100..0x104 = 1..5; copy src=0x101, dst=0x100, len=4 -> 0x100..0x103 = 2,3,4,5.
- Descending overlapped copy: same preload; copy src=0x100, dst=0x101, len=4 -> 0x101..0x104 = 1,2,3,4; 0x100 = 1.
- Address wrap: fill dst=0x1FFFFE, len=4, fill=0x1234 -> 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001 written; 0x000002 unchanged.
- Host interaction: cpu_wr to 0x50 with value 0x7 during RUN -> cpu_wr_ready=0 and 0x50 unchanged. Same write in IDLE, coincident with cmd acceptance -> 0x50 = 0x7. cpu_rd_addr appears on mem_rd_addr_b in every state.
- Boundaries:
  - cmd_len=0 -> single done pulse, busy never high, no writes.
  - reset asserted on 3rd cycle of a len=10 fill at 0x200 -> only 0x200..0x201 written; mem_wr=0 in the reset cycle; no done pulse; cmd_ready=1 the next cycle.
